// File: rtl/pipe_stage_buffer.sv
// Inter-stage valid/ready pipeline buffer: DEPTH-slot circular FIFO with flush and NOP bubble when empty.
// Define PIPE_STAGE_BUFFER_STATS_EN to add the saturating stall_cnt output.
module pipe_stage_buffer #(
    parameter int unsigned WIDTH = 41,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic [CNT_W-1:0] count
`ifdef PIPE_STAGE_BUFFER_STATS_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);

    localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_c;
    logic             pop_c;

    // Pointer wrap without assuming DEPTH is a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshake and head presentation depend only on registered state.
    always_comb begin
        in_ready  = (count_q != FULL_CNT);
        out_valid = (count_q != '0);
        push_c    = in_valid && in_ready && !flush;
        pop_c     = out_valid && out_ready && !flush;
        out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
        count     = count_q;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop_c)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({push_c, pop_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (push_c) mem_q[wr_ptr_q] <= in_data;
    end

`ifdef PIPE_STAGE_BUFFER_STATS_EN
    logic [15:0] stall_q;

    // Counts rejected offers; survives flush, cleared only by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (in_valid && !in_ready && !flush && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    // Stall statistics compiled out.
`endif

endmodule
